// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM read-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 128;

endpackage

// File: rtl/sdram_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching from ptr+1 upward, modulo N.
// Rotate so the search starts at bit 0, priority-encode, then rotate the index back.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] winner
);

  logic [N-1:0] rot;
  int           first;

  always_comb begin
    rot    = '0;
    first  = 0;
    valid  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[IW'((int'(ptr) + 1 + i) % N)];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = i;
    end
    valid  = |rot;
    winner = IW'((int'(ptr) + 1 + first) % N);
  end

endmodule

// File: rtl/sdram_rd_arbiter.sv
// Round-robin arbiter sharing the SDRAM read port; request-to-ack is 2 cycles plus controller latency.
// New reads start only from IDLE with sdram_wait low; an issued read always runs to its ack.
module sdram_rd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter  int NREQ = 3,
  parameter  int AW   = SDRAM_AW,
  parameter  int DW   = SDRAM_DW,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]  ack,
  output logic [DW-1:0]    rdata,
  output logic [GW-1:0]    grant_id,
  output logic             busy,
  input  logic             sdram_wait,
  input  logic             sdram_ac,
  input  logic [DW-1:0]    sdram_data,
  output logic             sdram_rd,
  output logic [AW-1:0]    sdram_addr
);

  arb_state_t      state, state_nxt;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   pick;
  logic            pick_valid;
  logic            start;
  logic [AW-1:0]   pick_addr;

  rr_pick #(
    .N  (NREQ),
    .IW (GW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick)
  );

  assign start = (state == IDLE) && !sdram_wait && pick_valid;

  always_comb begin
    pick_addr = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == GW'(k)) pick_addr = req_addr[k*AW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack       = '0;
    busy      = 1'b0;
    sdram_rd  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy     = 1'b1;
        sdram_rd = 1'b1;
        if (sdram_ac) state_nxt = RESP;
      end
      RESP: begin
        busy          = 1'b1;
        ack[grant_id] = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset pointer NREQ-1 makes requester 0 the first to win.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= GW'(NREQ - 1);
      grant_id   <= '0;
      sdram_addr <= '0;
      rdata      <= '0;
    end else begin
      if (start) begin
        grant_id   <= pick;
        sdram_addr <= pick_addr;
      end
      if (state == ISSUE && sdram_ac) rdata <= sdram_data;
      if (state == RESP) ptr <= grant_id;
    end
  end

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed and randomized bench for sdram_rd_arbiter with a transaction-level round-robin model.
module tb_sdram_rd_arbiter;
  import sdram_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = SDRAM_AW;
  localparam int DW   = SDRAM_DW;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   ack;
  logic [DW-1:0]     rdata;
  logic [1:0]        grant_id;
  logic              busy;
  logic              sdram_wait;
  logic              sdram_ac;
  logic [DW-1:0]     sdram_data;
  logic              sdram_rd;
  logic [AW-1:0]     sdram_addr;

  int vectors     = 0;
  int miscompares = 0;

  logic [NREQ-1:0] rq;
  logic [AW-1:0]   addr [NREQ];
  int              last;
  logic [DW-1:0]   exp_rdata;

  sdram_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .ack        (ack),
    .rdata      (rdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .sdram_wait (sdram_wait),
    .sdram_ac   (sdram_ac),
    .sdram_data (sdram_data),
    .sdram_rd   (sdram_rd),
    .sdram_addr (sdram_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    req = rq;
    for (int k = 0; k < NREQ; k++) req_addr[k*AW +: AW] = addr[k];
  endtask

  task automatic raise(input logic [NREQ-1:0] nb);
    for (int k = 0; k < NREQ; k++) begin
      if (nb[k]) addr[k] = AW'($urandom);
    end
    rq = rq | nb;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Winner = first pending requester after the last one served, wrapping around.
  function automatic int rr(input logic [NREQ-1:0] r, input int after);
    for (int o = 1; o <= NREQ; o++) begin
      if (r[(after + o) % NREQ]) return (after + o) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int              w;
    int              lat;
    logic [DW-1:0]   d;
    logic [NREQ-1:0] nb;

    reset      = 1'b1;
    rq         = '0;
    for (int k = 0; k < NREQ; k++) addr[k] = '0;
    apply();
    sdram_wait = 1'b0;
    sdram_ac   = 1'b0;
    sdram_data = '0;
    step();
    step();
    chk("rst_ack",   128'(ack),        128'(0));
    chk("rst_rdata", 128'(rdata),      128'(0));
    chk("rst_gnt",   128'(grant_id),   128'(0));
    chk("rst_busy",  128'(busy),       128'(0));
    chk("rst_rd",    128'(sdram_rd),   128'(0));
    chk("rst_addr",  128'(sdram_addr), 128'(0));
    reset = 1'b0;
    last  = NREQ - 1;

    // Single request, controller answers 3 cycles after sdram_rd rises.
    addr[0] = 22'h310000;
    rq      = 3'b001;
    apply();
    step();
    chk("single_rd",   128'(sdram_rd),   128'(1));
    chk("single_addr", 128'(sdram_addr), 128'(22'h310000));
    chk("single_gnt",  128'(grant_id),   128'(0));
    chk("single_busy", 128'(busy),       128'(1));
    repeat (3) begin
      step();
      chk("single_hold", 128'(sdram_rd), 128'(1));
      chk("single_noack", 128'(ack), 128'(0));
    end
    d          = {16{8'hA5}};
    sdram_ac   = 1'b1;
    sdram_data = d;
    step();
    sdram_ac   = 1'b0;
    sdram_data = rnd_data();
    chk("single_ack",   128'(ack),      128'(3'b001));
    chk("single_rdata", rdata,          d);
    chk("single_rd0",   128'(sdram_rd), 128'(0));
    rq = '0;
    apply();
    step();
    chk("single_ack1",  128'(ack),  128'(0));
    chk("single_idle",  128'(busy), 128'(0));
    chk("single_keep",  rdata,      d);
    last = 0;

    // sdram_wait blocks new reads; minimum latency once released.
    addr[1]    = AW'($urandom);
    rq         = 3'b010;
    sdram_wait = 1'b1;
    apply();
    repeat (20) begin
      step();
      chk("wait_rd", 128'(sdram_rd), 128'(0));
    end
    sdram_wait = 1'b0;
    step();
    chk("wait_rd1",  128'(sdram_rd),   128'(1));
    chk("wait_addr", 128'(sdram_addr), 128'(addr[1]));
    chk("wait_gnt",  128'(grant_id),   128'(1));
    d          = rnd_data();
    sdram_ac   = 1'b1;
    sdram_data = d;
    step();
    sdram_ac = 1'b0;
    chk("minlat_ack",   128'(ack), 128'(3'b010));
    chk("minlat_rdata", rdata,     d);
    rq = '0;
    apply();
    step();
    last = 1;

    // Reset in the middle of a read, then the stale ac pulse arrives.
    addr[0] = AW'($urandom);
    rq      = 3'b001;
    apply();
    step();
    chk("mid_rd", 128'(sdram_rd), 128'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_ack",   128'(ack),        128'(0));
    chk("mid_rdata", 128'(rdata),      128'(0));
    chk("mid_gnt",   128'(grant_id),   128'(0));
    chk("mid_busy",  128'(busy),       128'(0));
    chk("mid_rd0",   128'(sdram_rd),   128'(0));
    chk("mid_addr",  128'(sdram_addr), 128'(0));
    last = NREQ - 1;
    addr[1]    = AW'($urandom);
    addr[2]    = AW'($urandom);
    rq         = 3'b111;
    sdram_ac   = 1'b1;
    sdram_data = rnd_data();
    apply();
    step();
    sdram_ac = 1'b0;
    chk("mid_noack", 128'(ack),      128'(0));
    chk("mid_gnt0",  128'(grant_id), 128'(0));
    chk("mid_rd1",   128'(sdram_rd), 128'(1));
    d          = rnd_data();
    sdram_ac   = 1'b1;
    sdram_data = d;
    step();
    sdram_ac = 1'b0;
    chk("mid_ack0", 128'(ack), 128'(3'b001));
    exp_rdata = d;
    last      = 0;
    rq        = 3'b110;
    apply();
    step();

    // Random traffic: late joiners, re-requests, wait toggling, stray ac pulses in IDLE.
    for (int n = 0; n < 300; n++) begin
      nb = NREQ'($urandom) & ~rq;
      if ($urandom_range(0, 1) == 0) raise(nb);
      sdram_wait = ($urandom_range(0, 3) == 0);
      sdram_ac   = ($urandom_range(0, 7) == 0);
      sdram_data = rnd_data();
      apply();
      w = sdram_wait ? -1 : rr(rq, last);
      step();
      sdram_ac = 1'b0;
      if (w < 0) begin
        chk("idle_rd",    128'(sdram_rd), 128'(0));
        chk("idle_busy",  128'(busy),     128'(0));
        chk("idle_ack",   128'(ack),      128'(0));
        chk("idle_rdata", rdata,          exp_rdata);
      end else begin
        chk("iss_rd",   128'(sdram_rd),   128'(1));
        chk("iss_gnt",  128'(grant_id),   128'(w));
        chk("iss_addr", 128'(sdram_addr), 128'(addr[w]));
        chk("iss_ack",  128'(ack),        128'(0));
        lat = $urandom_range(0, 3);
        for (int l = 0; l < lat; l++) begin
          raise(NREQ'($urandom) & ~rq);
          sdram_wait = 1'($urandom);
          apply();
          step();
          chk("hold_rd",   128'(sdram_rd),   128'(1));
          chk("hold_addr", 128'(sdram_addr), 128'(addr[w]));
        end
        d          = rnd_data();
        sdram_ac   = 1'b1;
        sdram_data = d;
        step();
        sdram_ac   = 1'b0;
        sdram_data = rnd_data();
        chk("resp_ack",   128'(ack),      128'(1) << w);
        chk("resp_rdata", rdata,          d);
        chk("resp_rd",    128'(sdram_rd), 128'(0));
        exp_rdata = d;
        last      = w;
        if ($urandom_range(0, 2) != 0) rq[w] = 1'b0;
        else addr[w] = AW'($urandom);
        apply();
        step();
        chk("post_ack",  128'(ack),  128'(0));
        chk("post_busy", 128'(busy), 128'(0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_rd_arbiter.md
# sdram_rd_arbiter

Round-robin arbiter that shares the single SDRAM read port between several on-chip requesters: the boot-time memory initialiser, the sprite/tile fetcher and the audio sample fetcher. Each requester presents a 22-bit word address and gets back one 128-bit line with a one-cycle acknowledge. The block sits between the SDRAM controller's read interface and the requesters, and is the only driver of `sdram_rd` and `sdram_addr`.

## Interface
Parameters:
- `NREQ`, 3: number of requesters (2..8).
- `AW`, 22: SDRAM word address width.
- `DW`, 128: read data width.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester read request. Level-sensitive; held until that requester's `ack`.
- `req_addr`  in  NREQ*AW  packed addresses; requester k uses bits [k*AW +: AW]. Stable while `req[k]` is high.
- `ack`  out  NREQ  one-hot, one-cycle pulse: the request has completed and `rdata` is valid.
- `rdata`  out  DW  registered read data; valid in the `ack` cycle and held until the next completion.
- `grant_id`  out  $clog2(NREQ)  index of the requester currently being served (debug).
- `busy`  out  1  high in every state except IDLE.
- `sdram_wait`  in  1  SDRAM controller not ready (init/refresh); no new read starts while high.
- `sdram_ac`  in  1  one-cycle pulse from the controller: `sdram_data` is valid, sampled synchronously.
- `sdram_data`  in  DW  SDRAM read data.
- `sdram_rd`  out  1  read strobe to the controller.
- `sdram_addr`  out  AW  registered read address to the controller.

## Operation
- States are IDLE, ISSUE and RESP.
- **IDLE:**
  - If `sdram_wait`=0 and `req`≠0, pick the winner with `rr_pick`.
  - Latch the winner's address into `sdram_addr` and its index into `grant_id`, then go to ISSUE.
  - Otherwise stay in IDLE. `sdram_ac` is ignored in IDLE.
- **ISSUE:**
  - `sdram_rd`=1 and `sdram_addr` is held.
  - On a cycle with `sdram_ac`=1, capture `sdram_data` into `rdata` and go to RESP.
  - `sdram_wait` rising during ISSUE does not abort the read; keep waiting for `sdram_ac`.
- **RESP:**
  - `ack[grant_id]`=1 for exactly this cycle and `sdram_rd`=0.
  - Set the priority pointer to `grant_id`, then go to IDLE.
- **Round-robin rule:**
  - Search order is ptr+1, ptr+2, … modulo NREQ; the first set `req` bit wins.
  - A requester with a continuous stream of requests therefore cannot starve the others.
- **Requester contract:**
  - Clear `req[k]` on the clock edge where `ack[k]`=1, or keep it high to issue a new request.
  - A `req` seen high in IDLE is always treated as a new request.
  - Deasserting `req` before `ack` is illegal. The arbiter completes the read anyway and still pulses `ack`.
- Requests not granted are never lost; they are served in a later arbitration.
- Reset values: state IDLE, pointer NREQ-1 (requester 0 has first priority), all outputs 0 (`ack`, `rdata`, `grant_id`, `busy`, `sdram_rd`, `sdram_addr`).
- Reset mid-read returns the block to IDLE immediately. The outstanding `sdram_ac` is ignored and no `ack` is produced.

## Timing
- `req` high in cycle 0 (IDLE, `sdram_wait`=0):
  - cycle 1: ISSUE, `sdram_rd`=1.
  - `sdram_ac` arrives in cycle n ≥ 1.
  - cycle n+1: `ack` and `rdata` valid.
  - Minimum latency from request to `ack` is 2 cycles.
- Back-to-back throughput: one read every (ac latency + 2) cycles; IDLE costs one cycle between reads.
- Simultaneous requests in one IDLE cycle: exactly one grant; the rest wait.
- `sdram_addr` changes only on the IDLE→ISSUE transition.
- `rdata` changes only on the ISSUE→RESP transition.

## Structure
- Package `sdram_arb_pkg`:
  - state enum `arb_state_t` (IDLE, ISSUE, RESP);
  - constants `SDRAM_AW`=22 and `SDRAM_DW`=128.
- Sub-module `rr_pick`, combinational:
  - inputs `req` and `ptr`;
  - outputs a `valid` flag and the winner index;
  - implemented as rotate, priority-encode, rotate back.
- The top level holds the FSM, the registers and the output decode.

## Test plan
- **Single request:** reset, then `req`=001 with address 22'h310000, `sdram_ac` 3 cycles after `sdram_rd` rises, data 128'hA5A5… → `sdram_addr`=22'h310000, `ack`=001 exactly one cycle, `rdata`=128'hA5A5…, `busy` low after RESP.
- **Contention fairness:** `req`=111 held continuously, `ack` re-raising each request → grant order 0,1,2,0,1,2; no requester acknowledged twice in a row.
- **`sdram_wait` gating:** `sdram_wait`=1 for 20 cycles with `req`=010 → `sdram_rd` stays 0. After `sdram_wait` falls, `sdram_rd` rises exactly 1 cycle later with requester 1's address.
- **Late joiner:** `req`=001 being served; `req[2]` rises during ISSUE → requester 2 is granted next; `rdata` for requester 0 is unaffected.
- **Reset mid-read:** reset asserted during ISSUE, then `sdram_ac` pulses → no `ack`, all outputs 0. The next grant goes to requester 0.
- **Minimum latency:** `sdram_ac` in the first ISSUE cycle → `ack` 2 cycles after `req` was sampled.
